// File: rtl/mod_n_count_monitor.sv
// Checks a mod-N count stream: hold or +1 mod N, counts wraps, flags faults.
// Latency: one cycle; outputs reflect the sample taken at the previous edge.
// Backpressure: none; en qualifies each sample and q_in is never stalled.
module mod_n_count_monitor #(
  parameter int N      = 3,
  parameter int W      = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [W-1:0]      q_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic              range_err
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Compares run one bit wider so N = 2^W and prev+1 never overflow.
  localparam logic [W:0] N_EXT = (W+1)'(N);
  localparam logic [W:0] LAST  = (W+1)'(N - 1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t       state;
  logic [W-1:0] prev;
  logic [W:0]   q_ext;
  logic [W:0]   prev_inc;
  logic         in_range;
  logic         is_last;

  // Widened views of the sample and the previous count for the step checks.
  always_comb begin
    q_ext    = {1'b0, q_in};
    prev_inc = {1'b0, prev} + 1'b1;
    in_range = (q_ext < N_EXT);
    is_last  = ({1'b0, prev} == LAST);
  end

  assign locked = (state == LOCKED);

  // Lock FSM, step/range checking, wrap pulse and saturating wrap tally.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= SYNC;
      prev       <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      step_err   <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (en) begin
        case (state)
          SYNC: begin
            // First in-range sample is taken as the reference, never a wrap.
            if (in_range) begin
              prev  <= q_in;
              state <= LOCKED;
            end else begin
              range_err <= 1'b1;
            end
          end
          LOCKED: begin
            if (!in_range) begin
              range_err <= 1'b1;
              state     <= FAULT;
            end else if (q_in == prev) begin
              // Legal hold: nothing changes.
              prev <= prev;
            end else if (is_last && (q_in == '0)) begin
              prev       <= '0;
              wrap_pulse <= 1'b1;
              if (wrap_count != WRAP_MAX) begin
                wrap_count <= wrap_count + 1'b1;
              end
            end else if (q_ext == prev_inc) begin
              prev <= q_in;
            end else begin
              // Illegal jump: flag it and resync on the new value at once.
              step_err <= 1'b1;
              prev     <= q_in;
            end
          end
          FAULT: begin
            // Only a clean zero re-acquires the count after a range fault.
            if (q_in == '0) begin
              prev  <= '0;
              state <= LOCKED;
            end else if (!in_range) begin
              range_err <= 1'b1;
            end
          end
          default: begin
            state <= SYNC;
          end
        endcase
      end else if ((state != SYNC) && (state != LOCKED) && (state != FAULT)) begin
        state <= SYNC;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_count_monitor.sv
// Scoreboard bench for mod_n_count_monitor with N=3, W=3 (tally widths 8 and 2).
// Latency: expectations apply to outputs one edge after each driven sample.
// Backpressure: none; the monitor pops one expectation per sampled edge.
module tb_mod_n_count_monitor;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] q_in = 3'd0;

  logic       locked_a, wrap_pulse_a, step_err_a, range_err_a;
  logic [7:0] wrap_count_a;
  logic       locked_b, wrap_pulse_b, step_err_b, range_err_b;
  logic [1:0] wrap_count_b;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string tag;
    bit    lk;
    bit    wp;
    int    wc;
    bit    se;
    bit    re;
  } exp_t;

  exp_t sb[$];

  mod_n_count_monitor #(.N(3), .W(3), .WRAP_W(8)) dut_a (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in),
    .locked(locked_a), .wrap_pulse(wrap_pulse_a), .wrap_count(wrap_count_a),
    .step_err(step_err_a), .range_err(range_err_a)
  );

  mod_n_count_monitor #(.N(3), .W(3), .WRAP_W(2)) dut_b (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in),
    .locked(locked_b), .wrap_pulse(wrap_pulse_b), .wrap_count(wrap_count_b),
    .step_err(step_err_b), .range_err(range_err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input string tag, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s/%s: got %0d, expected %0d", tag, name, act, req);
    end
  endtask

  // Drive one sample at the falling edge and queue what must follow the next rising edge.
  task automatic drive(input string tag, input bit c, input bit e, input int q,
                       input bit lk, input bit wp, input int wc, input bit se, input bit re);
    exp_t x;
    @(negedge clk);
    clr  = c;
    en   = e;
    q_in = 3'(q);
    x.tag = tag; x.lk = lk; x.wp = wp; x.wc = wc; x.se = se; x.re = re;
    sb.push_back(x);
  endtask

  // Monitor: after each rising edge, compare both DUTs against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("locked",     x.tag, int'(locked_a),     int'(x.lk));
        check("wrap_pulse", x.tag, int'(wrap_pulse_a), int'(x.wp));
        check("wrap_count", x.tag, int'(wrap_count_a), x.wc);
        check("step_err",   x.tag, int'(step_err_a),   int'(x.se));
        check("range_err",  x.tag, int'(range_err_a),  int'(x.re));
        check("b_locked",     x.tag, int'(locked_b),     int'(x.lk));
        check("b_wrap_pulse", x.tag, int'(wrap_pulse_b), int'(x.wp));
        check("b_wrap_count", x.tag, int'(wrap_count_b), (x.wc > 3) ? 3 : x.wc);
        check("b_step_err",   x.tag, int'(step_err_b),   int'(x.se));
        check("b_range_err",  x.tag, int'(range_err_b),  int'(x.re));
      end
    end
  end

  initial begin
    int waited;
    //          tag      clr en q   lk wp wc se re
    drive("reset",    1, 0, 0,   0, 0, 0, 0, 0);

    // Plain counting with two wraps.
    drive("t1",       0, 1, 0,   1, 0, 0, 0, 0);
    drive("t1",       0, 1, 1,   1, 0, 0, 0, 0);
    drive("t1",       0, 1, 2,   1, 0, 0, 0, 0);
    drive("t1_wrap",  0, 1, 0,   1, 1, 1, 0, 0);
    drive("t1",       0, 1, 1,   1, 0, 1, 0, 0);
    drive("t1",       0, 1, 2,   1, 0, 1, 0, 0);
    drive("t1_wrap",  0, 1, 0,   1, 1, 2, 0, 0);
    drive("t1_idle",  0, 0, 2,   1, 0, 2, 0, 0);

    // Holds with en toggling; en=0 samples of other values are ignored.
    drive("t2_clr",   1, 1, 0,   0, 0, 0, 0, 0);
    drive("t2",       0, 1, 0,   1, 0, 0, 0, 0);
    drive("t2",       0, 0, 2,   1, 0, 0, 0, 0);
    drive("t2",       0, 1, 0,   1, 0, 0, 0, 0);
    drive("t2",       0, 0, 5,   1, 0, 0, 0, 0);
    drive("t2",       0, 1, 1,   1, 0, 0, 0, 0);
    drive("t2",       0, 0, 0,   1, 0, 0, 0, 0);
    drive("t2",       0, 1, 1,   1, 0, 0, 0, 0);
    drive("t2",       0, 0, 0,   1, 0, 0, 0, 0);
    drive("t2",       0, 1, 2,   1, 0, 0, 0, 0);
    drive("t2",       0, 0, 1,   1, 0, 0, 0, 0);
    drive("t2",       0, 1, 2,   1, 0, 0, 0, 0);
    drive("t2_wrap",  0, 1, 0,   1, 1, 1, 0, 0);

    // Skip 0->2 flags step_err and resyncs, so the following 0 is a wrap.
    drive("t3_clr",   1, 0, 0,   0, 0, 0, 0, 0);
    drive("t3",       0, 1, 0,   1, 0, 0, 0, 0);
    drive("t3_skip",  0, 1, 2,   1, 0, 0, 1, 0);
    drive("t3_wrap",  0, 1, 0,   1, 1, 1, 1, 0);

    // Range fault from LOCKED, ignored values in FAULT, re-lock on zero.
    drive("t4",       0, 1, 1,   1, 0, 1, 1, 0);
    drive("t4_range", 0, 1, 3,   0, 0, 1, 1, 1);
    drive("t4_fault", 0, 1, 1,   0, 0, 1, 1, 1);
    drive("t4_fault", 0, 1, 7,   0, 0, 1, 1, 1);
    drive("t4_relock",0, 1, 0,   1, 0, 1, 1, 1);

    // Out-of-range in SYNC keeps SYNC; first zero locks without a wrap.
    drive("sync_clr", 1, 0, 0,   0, 0, 0, 0, 0);
    drive("sync_rng", 0, 1, 5,   0, 0, 0, 0, 1);
    drive("sync_lock",0, 1, 0,   1, 0, 0, 0, 1);

    // Six 0,1,2 rounds plus a closing 0: six wraps; the 2-bit tally pins at 3.
    drive("t5_clr",   1, 0, 0,   0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive("t5_zero", 0, 1, 0,  1, (k != 0), k, 0, 0);
      drive("t5",      0, 1, 1,  1, 0, k, 0, 0);
      drive("t5",      0, 1, 2,  1, 0, k, 0, 0);
    end
    drive("t5_zero",  0, 1, 0,   1, 1, 6, 0, 0);

    // clr beats a pending wrap in the same cycle.
    drive("t6",       0, 1, 1,   1, 0, 6, 0, 0);
    drive("t6",       0, 1, 2,   1, 0, 6, 0, 0);
    drive("t6_clr",   1, 1, 0,   0, 0, 0, 0, 0);
    drive("t6_lock",  0, 1, 0,   1, 0, 0, 0, 0);

    // 1->0 is a step error, not a wrap.
    drive("t7",       0, 1, 1,   1, 0, 0, 0, 0);
    drive("t7_back",  0, 1, 0,   1, 0, 0, 1, 0);
    drive("t7_idle",  0, 0, 0,   1, 0, 0, 1, 0);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
